// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO responder: LED output register, debounced switches, edge capture and IRQ.
// Latency 1 cycle per request, no backpressure: every we/re gets exactly one ready pulse.
module mips_gpio_port #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic [7:0]  sw_in,
   output logic [7:0]  gpio_o,
   output logic        irq
);

   localparam logic [1:0] REG_OUT  = 2'd0;
   localparam logic [1:0] REG_SW   = 2'd1;
   localparam logic [1:0] REG_EDGE = 2'd2;
   localparam logic [1:0] REG_IEN  = 2'd3;
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   typedef struct packed {
      logic [7:0] irq_en;
      logic [7:0] edge_q;
      logic [7:0] gpio_out;
   } regs_t;

   regs_t           regs_q;
   regs_t           regs_nxt;
   logic [7:0]      s1;
   logic [7:0]      s2;
   logic [7:0]      stable;
   logic [7:0]      stable_nxt;
   logic [7:0][7:0] deb_cnt;
   logic [7:0][7:0] deb_cnt_nxt;
   logic [7:0]      rise;
   logic            hit;
   logic [1:0]      sel;
   logic            wr;
   logic            rd;
   logic [7:0]      edge_clr;
   logic [31:0]     rd_val;
   logic            unused_ok;

   assign unused_ok = ^{wdata[31:8], addr[1:0]};

   // Two-flop synchronizer for the asynchronous switch pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 8'd0;
         s2 <= 8'd0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   always_comb begin
      stable_nxt  = stable;
      deb_cnt_nxt = '0;
      for (int i = 0; i < 8; i++) begin
         if (s2[i] != stable[i]) begin
            if (deb_cnt[i] == DEB_LAST) begin
               stable_nxt[i] = s2[i];
            end else begin
               deb_cnt_nxt[i] = deb_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign rise = stable_nxt & ~stable;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable  <= 8'd0;
         deb_cnt <= '0;
      end else begin
         stable  <= stable_nxt;
         deb_cnt <= deb_cnt_nxt;
      end
   end

   // A simultaneous we/re is handled as a write only.
   assign hit = (addr[31:4] == BASE_ADDR[31:4]);
   assign sel = addr[3:2];
   assign wr  = we & hit;
   assign rd  = re & ~we;

   assign edge_clr = (wr && sel == REG_EDGE) ? wdata[7:0] : 8'd0;

   always_comb begin
      regs_nxt        = regs_q;
      regs_nxt.edge_q = (regs_q.edge_q & ~edge_clr) | rise;
      if (wr && sel == REG_OUT) begin
         regs_nxt.gpio_out = wdata[7:0];
      end
      if (wr && sel == REG_IEN) begin
         regs_nxt.irq_en = wdata[7:0];
      end
   end

   always_comb begin
      rd_val = 32'd0;
      if (hit) begin
         case (sel)
            REG_OUT:  rd_val = {24'd0, regs_q.gpio_out};
            REG_SW:   rd_val = {24'd0, stable};
            REG_EDGE: rd_val = {24'd0, regs_q.edge_q};
            REG_IEN:  rd_val = {24'd0, regs_q.irq_en};
            default:  rd_val = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '0;
         ready  <= 1'b0;
         rdata  <= 32'd0;
      end else begin
         regs_q <= regs_nxt;
         ready  <= we | re;
         if (rd) begin
            rdata <= rd_val;
         end
      end
   end

   assign gpio_o = regs_q.gpio_out;
   assign irq    = |(regs_q.edge_q & regs_q.irq_en);

endmodule

// File: tb/tb_mips_gpio_port.sv
// Directed bench for mips_gpio_port: bus access, debounce timing, edge W1C and reset behaviour.
module tb_mips_gpio_port;

   localparam logic [31:0] A_OUT  = 32'h0000_0100;
   localparam logic [31:0] A_SW   = 32'h0000_0104;
   localparam logic [31:0] A_EDGE = 32'h0000_0108;
   localparam logic [31:0] A_IEN  = 32'h0000_010C;
   localparam logic [31:0] A_MISS = 32'h0000_0110;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic [7:0]  sw_in = 8'd0;
   logic [7:0]  gpio_o;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   mips_gpio_port #(.BASE_ADDR(32'h0000_0100), .DEB_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .ready(ready), .sw_in(sw_in), .gpio_o(gpio_o), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic rdy);
      addr = a; wdata = d; we = 1'b1;
      tick();
      rdy = ready;
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
      addr = a; re = 1'b1;
      tick();
      d = rdata;
      rdy = ready;
      re = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
      n_vec++; if (gpio_o !== 8'd0) begin n_err++; $display("FAIL reset_gpio got %h want 0", gpio_o); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      logic [31:0] d;
      logic r;
      bus_write(A_OUT, 32'hFFFF_FFA5, r);
      n_vec++; if (r !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b want 1", r); end
      n_vec++; if (gpio_o !== 8'hA5) begin n_err++; $display("FAIL wr_gpio got %h want a5", gpio_o); end
      bus_read(A_OUT, d, r);
      n_vec++; if (r !== 1'b1) begin n_err++; $display("FAIL rd_ready got %b want 1", r); end
      n_vec++; if (d !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_gpio got %h want 000000a5", d); end
      tick();
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ready_pulse got %b want 0", ready); end
      bus_read(32'h0000_0103, d, r);
      n_vec++; if (d !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_low_addr got %h want 000000a5", d); end
   endtask

   task automatic test_switch();
      logic [31:0] d;
      logic [31:0] exp;
      logic r;
      sw_in = 8'h81;
      addr = A_SW; re = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick();
         exp = (j == 6) ? 32'h81 : 32'h0;
         n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL sw_b2b_ready[%0d] got %b want 1", j, ready); end
         n_vec++; if (rdata !== exp) begin n_err++; $display("FAIL sw_latency[%0d] got %h want %h", j, rdata, exp); end
      end
      re = 1'b0;
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL edge_set got %h want 81", d); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled got %b want 0", irq); end
      bus_write(A_IEN, 32'h01, r);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_enabled got %b want 1", irq); end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      logic r;
      sw_in = 8'h89;
      repeat (3) tick();
      sw_in = 8'h81;
      repeat (10) tick();
      bus_read(A_SW, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL glitch3_sw got %h want 81", d); end
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL glitch3_edge got %h want 81", d); end
      sw_in = 8'h89;
      repeat (4) tick();
      sw_in = 8'h81;
      repeat (2) tick();
      bus_read(A_SW, d, r);
      n_vec++; if (d !== 32'h89) begin n_err++; $display("FAIL hold4_sw got %h want 89", d); end
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h89) begin n_err++; $display("FAIL hold4_edge got %h want 89", d); end
      repeat (10) tick();
      bus_read(A_SW, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL hold4_release got %h want 81", d); end
   endtask

   task automatic test_w1c();
      logic [31:0] d;
      logic r;
      bus_write(A_EDGE, 32'h09, r);
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL w1c_partial got %h want 80", d); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b want 0", irq); end
      bus_write(A_EDGE, 32'h80, r);
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL w1c_all got %h want 00", d); end
      sw_in = 8'h01;
      repeat (10) tick();
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL fall_no_edge got %h want 00", d); end
      sw_in = 8'h81;
      repeat (5) tick();
      bus_write(A_EDGE, 32'h80, r);
      bus_read(A_EDGE, d, r);
      n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL set_beats_clear got %h want 80", d); end
   endtask

   task automatic test_misc();
      logic [31:0] d;
      logic r;
      bus_read(A_SW, d, r);
      bus_read(A_MISS, d, r);
      n_vec++; if (r !== 1'b1) begin n_err++; $display("FAIL miss_ready got %b want 1", r); end
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL miss_rdata got %h want 0", d); end
      bus_write(A_SW, 32'hFF, r);
      n_vec++; if (r !== 1'b1) begin n_err++; $display("FAIL ro_wr_ready got %b want 1", r); end
      bus_read(A_SW, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL ro_ignored got %h want 81", d); end
      bus_write(A_MISS, 32'h5A, r);
      bus_read(A_OUT, d, r);
      n_vec++; if (d !== 32'hA5) begin n_err++; $display("FAIL miss_wr_ignored got %h want a5", d); end
      addr = A_OUT; wdata = 32'h3C; we = 1'b1; re = 1'b1;
      tick();
      we = 1'b0; re = 1'b0;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL wr_rd_ready got %b want 1", ready); end
      n_vec++; if (rdata !== 32'hA5) begin n_err++; $display("FAIL wr_rd_rdata got %h want a5", rdata); end
      n_vec++; if (gpio_o !== 8'h3C) begin n_err++; $display("FAIL wr_rd_gpio got %h want 3c", gpio_o); end
      tick();
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_rd_single got %b want 0", ready); end
      bus_write(A_OUT, 32'h77, r);
      bus_read(A_OUT, d, r);
      n_vec++; if (d !== 32'h77) begin n_err++; $display("FAIL b2b_wr_rd got %h want 77", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [31:0] exp;
      logic r;
      bus_write(A_IEN, 32'h80, r);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq got %b want 1", irq); end
      sw_in = 8'h42;
      repeat (3) tick();
      bus_read(A_SW, d, r);
      n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL mid_deb_sw got %h want 81", d); end
      reset = 1'b1;
      #1;
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
      n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata); end
      n_vec++; if (gpio_o !== 8'd0) begin n_err++; $display("FAIL rst_gpio got %h want 0", gpio_o); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
      tick();
      reset = 1'b0;
      addr = A_SW; re = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick();
         exp = (j == 6) ? 32'h42 : 32'h0;
         n_vec++; if (rdata !== exp) begin n_err++; $display("FAIL rst_sw_latency[%0d] got %h want %h", j, rdata, exp); end
      end
      re = 1'b0;
      bus_read(A_IEN, d, r);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_ien got %h want 0", d); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_switch();
      test_glitch();
      test_w1c();
      test_misc();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
